// File: rtl/toccata_pkg.sv
// Shared constants and sizing helpers for the
// watermark FIFO and its storage.
package toccata_pkg;

  localparam int DEF_DW    = 16;
  localparam int DEF_DEPTH = 1024;
  localparam int DEF_HYST  = 8;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/toccata_fifo_ram.sv
// Simple dual-port storage: one write port and
// one registered read port; the array is never reset.
module toccata_fifo_ram #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Output register holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/toccata_wm_fifo.sv
// Sample FIFO with occupancy level, hysteretic
// watermark pulses and sticky overflow/underflow.
module toccata_wm_fifo
  import toccata_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DW,
  parameter  int DEPTH      = DEF_DEPTH,
  parameter  int HYST       = DEF_HYST,
  localparam int LW         = lvl_w(DEPTH),
  localparam int AW         = LW - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           level,
  input  logic [AW:0]           lo_mark,
  input  logic [AW:0]           hi_mark,
  output logic                  lo_irq,
  output logic                  hi_irq,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [AW:0]   DEPTH_L = LW'(DEPTH);
  localparam logic [AW+1:0] HYST_L  = (AW+2)'(HYST);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [AW:0]   prev_q, prev_d;
  logic          lo_arm_q, lo_arm_d;
  logic          hi_arm_q, hi_arm_d;
  logic          lo_irq_q, lo_irq_d;
  logic          hi_irq_q, hi_irq_d;
  logic          rd_valid_q, rd_valid_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic          wr_acc, rd_acc;
  logic          lo_fire, hi_fire;
  logic [AW+1:0] lvl_x, lo_thr, hi_sum;

  assign full  = (level_q == DEPTH_L);
  assign empty = (level_q == '0);

  always_comb begin
    wr_acc = wr_en && !full && !flush;
    rd_acc = rd_en && !empty && !flush;
  end

  // Extra bit keeps the arm thresholds from wrapping.
  always_comb begin
    lvl_x   = {1'b0, level_q};
    lo_thr  = {1'b0, lo_mark} + HYST_L;
    hi_sum  = lvl_x + HYST_L;
    lo_fire = lo_arm_q && (prev_q > lo_mark)
              && (level_q <= lo_mark);
    hi_fire = hi_arm_q && (prev_q < hi_mark)
              && (level_q >= hi_mark);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    prev_d     = level_q;
    lo_arm_d   = lo_arm_q;
    hi_arm_d   = hi_arm_q;
    lo_irq_d   = lo_fire;
    hi_irq_d   = hi_fire;
    rd_valid_d = rd_acc;
    ovf_d      = (ovf_q && !err_clr) || (wr_en && full);
    udf_d      = (udf_q && !err_clr) || (rd_en && empty);

    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    unique case (1'b1)
      lo_fire:          lo_arm_d = 1'b0;
      (lvl_x >= lo_thr): lo_arm_d = 1'b1;
      default:          lo_arm_d = lo_arm_q;
    endcase

    unique case (1'b1)
      hi_fire:                    hi_arm_d = 1'b0;
      (hi_sum <= {1'b0, hi_mark}): hi_arm_d = 1'b1;
      default:                    hi_arm_d = hi_arm_q;
    endcase

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      prev_d     = '0;
      lo_arm_d   = 1'b0;
      hi_arm_d   = 1'b0;
      lo_irq_d   = 1'b0;
      hi_irq_d   = 1'b0;
      rd_valid_d = 1'b0;
      ovf_d      = 1'b0;
      udf_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      prev_q     <= '0;
      lo_arm_q   <= 1'b0;
      hi_arm_q   <= 1'b0;
      lo_irq_q   <= 1'b0;
      hi_irq_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      prev_q     <= prev_d;
      lo_arm_q   <= lo_arm_d;
      hi_arm_q   <= hi_arm_d;
      lo_irq_q   <= lo_irq_d;
      hi_irq_q   <= hi_irq_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  toccata_fifo_ram #(
    .DW(DATA_WIDTH),
    .AW(AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (data_out)
  );

  assign level     = level_q;
  assign rd_valid  = rd_valid_q;
  assign lo_irq    = lo_irq_q;
  assign hi_irq    = hi_irq_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_toccata_wm_fifo.sv
// Randomised and directed bench for toccata_wm_fifo
// against a queue-based reference model.
module tb_toccata_wm_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int HYST  = 4;

  logic          clk = 0;
  logic          rst_n = 1;
  logic          flush = 0;
  logic          wr_en = 0;
  logic [DW-1:0] data_in = 0;
  logic          rd_en = 0;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic [4:0]    level;
  logic [4:0]    lo_mark = 5'd4;
  logic [4:0]    hi_mark = 5'd12;
  logic          lo_irq;
  logic          hi_irq;
  logic          err_clr = 0;
  logic          overflow;
  logic          underflow;

  toccata_wm_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .HYST(HYST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(data_out),
    .rd_valid(rd_valid), .full(full), .empty(empty),
    .level(level), .lo_mark(lo_mark), .hi_mark(hi_mark),
    .lo_irq(lo_irq), .hi_irq(hi_irq), .err_clr(err_clr),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input longint got,
                     input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, got, exp, $time);
  endtask

  // Reference model: contents as a queue, flags as bits.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = 0;
  bit m_rv = 0, m_ovf = 0, m_udf = 0;
  bit m_loarm = 0, m_hiarm = 0, m_loirq = 0, m_hiirq = 0;
  int m_prev = 0;
  int m_lvl, m_lm, m_hm;
  bit m_full, m_empty, m_wa, m_ra, m_lf, m_hf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_dout = 0; m_rv = 0; m_ovf = 0; m_udf = 0;
      m_loarm = 0; m_hiarm = 0; m_loirq = 0; m_hiirq = 0;
      m_prev = 0;
    end else begin
      m_lvl = q.size();
      m_lm = int'(lo_mark);
      m_hm = int'(hi_mark);
      m_full = (m_lvl == DEPTH);
      m_empty = (m_lvl == 0);
      m_wa = wr_en && !m_full && !flush;
      m_ra = rd_en && !m_empty && !flush;
      m_lf = m_loarm && m_prev > m_lm && m_lvl <= m_lm;
      m_hf = m_hiarm && m_prev < m_hm && m_lvl >= m_hm;
      if (flush) begin
        q.delete();
        m_rv = 0; m_ovf = 0; m_udf = 0;
        m_loarm = 0; m_hiarm = 0; m_loirq = 0; m_hiirq = 0;
        m_prev = 0;
      end else begin
        m_loirq = m_lf;
        m_hiirq = m_hf;
        if (m_lf) m_loarm = 0;
        else if (m_lvl >= m_lm + HYST) m_loarm = 1;
        if (m_hf) m_hiarm = 0;
        else if (m_lvl + HYST <= m_hm) m_hiarm = 1;
        m_ovf = (m_ovf && !err_clr) || (wr_en && m_full);
        m_udf = (m_udf && !err_clr) || (rd_en && m_empty);
        m_prev = m_lvl;
        m_rv = m_ra;
        if (m_ra) m_dout = q.pop_front();
        if (m_wa) q.push_back(data_in);
      end
    end
  end

  int lo_cnt = 0;
  int hi_cnt = 0;

  always @(negedge clk) begin
    chk("level", level, q.size());
    chk("full", full, q.size() == DEPTH);
    chk("empty", empty, q.size() == 0);
    chk("data_out", data_out, m_dout);
    chk("rd_valid", rd_valid, m_rv);
    chk("lo_irq", lo_irq, m_loirq);
    chk("hi_irq", hi_irq, m_hiirq);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_udf);
    if (lo_irq) lo_cnt++;
    if (hi_irq) hi_cnt++;
  end

  logic [DW-1:0] ctr = 16'h0100;

  task automatic step(input bit w, input logic [DW-1:0] d,
                      input bit r, input bit f = 0,
                      input bit c = 0);
    wr_en = w; data_in = d; rd_en = r;
    flush = f; err_clr = c;
    @(posedge clk);
    #2;
    wr_en = 0; rd_en = 0; flush = 0; err_clr = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, ctr, 0);
      ctr++;
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1);
  endtask

  int l0, h0;

  initial begin
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_dout", data_out, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1;

    // Fill to full, overflow, ordered drain.
    l0 = lo_cnt; h0 = hi_cnt;
    for (int i = 1; i <= 16; i++) step(1, 16'(i), 0);
    chk("fill_level", level, 16);
    chk("fill_full", full, 1);
    step(1, 16'h0011, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_level", level, 16);
    idle(2);
    chk("hi_once_fill", hi_cnt - h0, 1);
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 1);
      chk("rd_seq", data_out, i);
      chk("rd_seq_valid", rd_valid, 1);
    end
    idle(2);
    chk("drain_empty", empty, 1);
    chk("lo_once_drain", lo_cnt - l0, 1);
    step(0, 0, 0, 0, 1);
    chk("ovf_clr", overflow, 0);

    // Read on empty.
    step(0, 0, 1);
    chk("udf_set", underflow, 1);
    chk("udf_rv", rd_valid, 0);
    chk("udf_dout", data_out, 16);
    step(0, 0, 0, 0, 1);
    chk("udf_clr", underflow, 0);

    // Low watermark hysteresis.
    l0 = lo_cnt;
    fill(8); idle(2); drain(8); idle(2);
    chk("lo_fill8", lo_cnt - l0, 1);
    fill(7); idle(2); drain(7); idle(2);
    chk("lo_fill7", lo_cnt - l0, 1);
    fill(8); idle(2); drain(8); idle(2);
    chk("lo_refill8", lo_cnt - l0, 2);

    // High watermark hysteresis.
    h0 = hi_cnt;
    fill(12); idle(2);
    chk("hi_fill12", hi_cnt - h0, 1);
    drain(3); idle(2); fill(3); idle(2);
    chk("hi_dip9", hi_cnt - h0, 1);
    drain(4); idle(2); fill(4); idle(2);
    chk("hi_dip8", hi_cnt - h0, 2);
    drain(12); idle(2);

    // Simultaneous read/write at 0, 5 and 16.
    step(1, ctr, 1); ctr++;
    chk("rw_at0", level, 1);
    step(0, 0, 0, 0, 1);
    fill(4);
    step(1, ctr, 1); ctr++;
    chk("rw_at5", level, 5);
    fill(11);
    step(1, ctr, 1); ctr++;
    chk("rw_at16", level, 15);
    chk("rw_at16_ovf", overflow, 1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      step(1, ctr, 1); ctr++;
    end
    chk("rw_wrap_level", level, 15);
    drain(15); idle(2);

    // Flush beats a write; async reset mid-burst.
    fill(10);
    step(1, 16'h0099, 0, 1);
    chk("flush_level", level, 0);
    chk("flush_empty", empty, 1);
    step(0, 0, 1);
    chk("flush_nostore", rd_valid, 0);
    step(0, 0, 0, 0, 1);
    fill(3);
    step(0, 0, 1);
    wr_en = 1; data_in = ctr;
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_dout", data_out, 0);
    chk("arst_rv", rd_valid, 0);
    chk("arst_empty", empty, 1);
    @(posedge clk);
    #2;
    wr_en = 0;
    rst_n = 1;

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      int pw;
      pw = ((i / 150) % 2 == 0) ? 70 : 30;
      if ($urandom_range(0, 99) == 0)
        lo_mark = 5'($urandom_range(0, 20));
      if ($urandom_range(0, 99) == 0)
        hi_mark = 5'($urandom_range(0, 20));
      step($urandom_range(0, 99) < pw, 16'($urandom),
           $urandom_range(0, 99) < 100 - pw,
           $urandom_range(0, 199) == 0,
           $urandom_range(0, 29) == 0);
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/toccata_wm_fifo.md
TOCCATA_WM_FIFO -- requirements
Module: toccata_wm_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample word width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024, entries; power of two, >=16.
REQ-003 SHALL have parameter HYST, default 8, watermark re-arm distance in entries, 1..DEPTH/4.
REQ-004 SHALL have ports, in order: clk  in  1  single clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have: flush  in  1  synchronous clear of contents and status.
REQ-006 SHALL have: wr_en  in  1  write request; data_in  in  DATA_WIDTH  write data.
REQ-007 SHALL have: rd_en  in  1  read request; data_out  out  DATA_WIDTH  read data; rd_valid  out  1  data_out updated this cycle.
REQ-008 SHALL have: full  out  1; empty  out  1; level  out  AW+1 (AW=clog2(DEPTH))  current occupancy.
REQ-009 SHALL have: lo_mark, hi_mark  in  AW+1  programmable watermarks; lo_irq, hi_irq  out  1  watermark pulses.
REQ-010 SHALL have: err_clr  in  1; overflow, underflow  out  1  sticky error flags.

Function
REQ-011 Write SHALL be accepted iff wr_en && !full && !flush; accepted data written at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-012 Read SHALL be accepted iff rd_en && !empty && !flush; data_out = entry at rd_ptr one cycle later, rd_valid high that cycle only; rd_ptr increments modulo DEPTH.
REQ-013 data_out SHALL hold its value when no read is accepted.
REQ-014 full SHALL equal (level==DEPTH); empty SHALL equal (level==0); both combinational from level; all DEPTH entries usable.
REQ-015 level SHALL +1 on accepted write only, -1 on accepted read only, unchanged on both or neither.
REQ-016 Write when full SHALL be rejected even if a read is accepted the same cycle; read when empty SHALL be rejected even if a write is accepted the same cycle (no bypass).
REQ-017 Rejected write (wr_en && full) SHALL set overflow; rejected read (rd_en && empty) SHALL set underflow; both stay set until err_clr or flush or reset.
REQ-018 lo_arm SHALL set when level >= lo_mark+HYST (computed AW+2 bits, no wrap); lo_irq SHALL pulse one cycle when level falls from >lo_mark to <=lo_mark with lo_arm set, clearing lo_arm.
REQ-019 hi_arm SHALL set when level+HYST <= hi_mark (AW+2 bits); hi_irq SHALL pulse one cycle when level rises from <hi_mark to >=hi_mark with hi_arm set, clearing hi_arm.
REQ-020 Watermark crossing SHALL be evaluated on the registered level of the previous and current cycle; pulses appear the cycle after level reaches the mark.
REQ-021 Unreachable arm conditions (e.g. lo_mark+HYST > DEPTH) SHALL leave that IRQ permanently silent, not wrap.
REQ-022 Watermark changes SHALL take effect next cycle; no retroactive pulse.
REQ-023 flush SHALL, next cycle: pointers=0, level=0, arm flags=0, sticky flags=0, irq=0, rd_valid=0; data_out held; flush overrides wr_en/rd_en.

Reset
REQ-024 Assertion of rst_n low SHALL immediately clear pointers, level, arm flags, lo_irq, hi_irq, rd_valid, overflow, underflow, data_out to 0.
REQ-025 Memory contents SHALL not be reset; reset mid-transfer discards all data.
REQ-026 Deassertion SHALL be synchronised externally; block operates from the first clk edge after deassertion.

Structure
REQ-027 Package toccata_pkg SHALL hold a level-width function and the default DEPTH/HYST constants.
REQ-028 Storage SHALL be a sub-module toccata_fifo_ram: simple dual-port, one write port, one registered read port, inferable as block RAM; no reset on its array.
REQ-029 Control, level, watermark and error logic SHALL reside in toccata_wm_fifo.

Verification
REQ-030 DEPTH=16: write 16 words 0x0001..0x0010 -> full=1 at level 16; 17th write rejected, overflow=1; read 16 -> data 0x0001..0x0010 in order, one cycle latency, empty=1.
REQ-031 Empty FIFO, rd_en -> underflow=1, rd_valid=0, data_out unchanged; err_clr -> underflow=0 next cycle.
REQ-032 DEPTH=16, HYST=4, lo_mark=4: fill to 8, drain -> single lo_irq pulse when level hits 4; refill to 7, drain -> no pulse; refill to 8, drain -> pulse.
REQ-033 hi_mark=12, HYST=4: fill from 0 -> hi_irq once at level 12; drain to 9, refill -> none; drain to 8, refill -> pulse.
REQ-034 Simultaneous wr_en/rd_en at level 0, 5 and 16 -> level 1, 5, 15 respectively; pointers wrap cleanly over 40 cycles.
REQ-035 flush with wr_en at level 10 -> level 0, empty=1, no write stored; rst_n low mid-burst -> all outputs 0 asynchronously.
